// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: op encodings and bitwise evaluation helper for logic_unit_pipe.
// logic_eval works on LU_MAXW-bit vectors; callers zero-extend and slice to WIDTH.
package logic_unit_pkg;

    localparam int OP_W    = 3;
    localparam int LU_MAXW = 256;

    localparam logic [OP_W-1:0] OP_AND  = 3'd0;
    localparam logic [OP_W-1:0] OP_OR   = 3'd1;
    localparam logic [OP_W-1:0] OP_NAND = 3'd2;
    localparam logic [OP_W-1:0] OP_NOR  = 3'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
    localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
    localparam logic [OP_W-1:0] OP_NOTA = 3'd6;
    localparam logic [OP_W-1:0] OP_PASS = 3'd7;

    function automatic logic [LU_MAXW-1:0] logic_eval(
        input logic [OP_W-1:0]    op,
        input logic [LU_MAXW-1:0] a,
        input logic [LU_MAXW-1:0] b
    );
        logic [LU_MAXW-1:0] r;
        r = a;
        unique case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_NAND: r = ~(a & b);
            OP_NOR:  r = ~(a | b);
            OP_XOR:  r = a ^ b;
            OP_XNOR: r = ~(a ^ b);
            OP_NOTA: r = ~a;
            OP_PASS: r = a;
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// logic_unit_stage: one valid/ready register slice of DW bits.
// Ports: clk, rst_n, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module logic_unit_stage #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    // Ready ripples back combinationally so bubbles collapse.
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: WIDTH-bit 8-op logic slice behind a STAGES-deep elastic pipe.
// Ports: clk, rst_n, in_valid/in_ready, op, a, b, out_valid/out_ready, y, y_zero,
// y_par; with LOGIC_UNIT_STATS_EN also xfer_cnt (output handshakes) and busy.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_zero,
    output logic             y_par
`ifdef LOGIC_UNIT_STATS_EN
    ,
    output logic [15:0]      xfer_cnt,
    output logic             busy
`endif
);

    localparam int DW = WIDTH + 2;

    logic [LU_MAXW-1:0] a_ext;
    logic [LU_MAXW-1:0] b_ext;
    logic [LU_MAXW-1:0] r_ext;
    logic [WIDTH-1:0]   r;
    logic               unused_hi;

    always_comb begin
        a_ext = '0;
        b_ext = '0;
        a_ext[WIDTH-1:0] = a;
        b_ext[WIDTH-1:0] = b;
    end

    assign r_ext     = logic_eval(op, a_ext, b_ext);
    assign r         = r_ext[WIDTH-1:0];
    assign unused_hi = ^r_ext;

    logic [STAGES:0] v;
    logic [STAGES:0] rdy;
    logic [DW-1:0]   d [STAGES+1];

    assign v[0]        = in_valid;
    assign d[0]        = {r, ~|r, ^r};
    assign in_ready    = rdy[0];
    assign rdy[STAGES] = out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic_unit_stage #(
            .DW(DW)
        ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (v[k]),
            .in_ready (rdy[k]),
            .in_data  (d[k]),
            .out_valid(v[k+1]),
            .out_ready(rdy[k+1]),
            .out_data (d[k+1])
        );
    end

    assign out_valid         = v[STAGES];
    assign {y, y_zero, y_par} = d[STAGES];

`ifdef LOGIC_UNIT_STATS_EN
    assign busy = |v[STAGES:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (out_valid && out_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: random and directed stimulus against a queue model.
// Build with +define+LOGIC_UNIT_STATS_EN to also cover xfer_cnt/busy.
module tb_logic_unit_pipe;

    localparam int WIDTH  = 8;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_zero;
    logic             y_par;
`ifdef LOGIC_UNIT_STATS_EN
    logic [15:0]      xfer_cnt;
    logic             busy;
`endif

    logic_unit_pipe #(
        .WIDTH (WIDTH),
        .STAGES(STAGES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y        (y),
        .y_zero   (y_zero),
        .y_par    (y_par)
`ifdef LOGIC_UNIT_STATS_EN
        ,
        .xfer_cnt (xfer_cnt),
        .busy     (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic       z;
        logic       p;
        int         c;
    } exp_t;

    exp_t        q[$];
    logic [9:0]  seen[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          pops = 0;
    int          pushes = 0;
    bit          chk_lat = 0;
    bit          acc = 0;
    logic [15:0] xcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_y(input int o, input logic [7:0] x,
                                         input logic [7:0] w);
        case (o)
            0: return x & w;
            1: return x | w;
            2: return ~(x & w);
            3: return ~(x | w);
            4: return x ^ w;
            5: return ~(x ^ w);
            6: return ~x;
            default: return x;
        endcase
    endfunction

    // One clock: check outputs at negedge, update model, advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        chk("in_ready", in_ready, (q.size() < STAGES) || out_ready);
        if (out_valid && q.size() == 0) begin
            chk("out_valid_empty", out_valid, 0);
        end else if (out_valid) begin
            chk("y", y, q[0].y);
            chk("y_zero", y_zero, q[0].z);
            chk("y_par", y_par, q[0].p);
            if (out_ready) begin
                e = q.pop_front();
                if (chk_lat) chk("latency", cyc - e.c, STAGES);
                seen.push_back({y, y_zero, y_par});
                pops++;
                xcnt++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e.y = ref_y(int'(op), a, b);
            e.z = (e.y == 0);
            e.p = ^e.y;
            e.c = cyc;
            q.push_back(e);
            pushes++;
        end
`ifdef LOGIC_UNIT_STATS_EN
        chk("busy", busy, (q.size() > 0) || (acc && !out_valid));
`endif
        @(posedge clk);
        #1;
        cyc++;
`ifdef LOGIC_UNIT_STATS_EN
        chk("xfer_cnt", xfer_cnt, xcnt);
`endif
    endtask

    task automatic rand_in();
        in_valid = 1'b1;
        op = 3'($urandom_range(0, 7));
        a  = 8'($urandom);
        b  = 8'($urandom);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #3;
        q.delete();
        xcnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    logic [7:0] tbl [8];
    logic [7:0] first_y;
    int         base;
    int         n;

    initial begin
        tbl = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hA5};
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        a = '0;
        b = '0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_y_zero", y_zero, 0);
        chk("rst_y_par", y_par, 0);
        do_reset();
        chk("rst_in_ready", in_ready, 1);

        // Op sweep, back-to-back, latency checked.
        chk_lat = 1;
        out_ready = 1'b1;
        base = seen.size();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            op = 3'(i);
            a = 8'hA5;
            b = 8'h0F;
            step();
        end
        drain();
        for (int i = 0; i < 8; i++) chk($sformatf("sweep%0d", i), seen[base+i][9:2], tbl[i]);

        // Flags.
        base = seen.size();
        in_valid = 1'b1; op = 3'd4; a = 8'h3C; b = 8'h3C;
        step();
        op = 3'd7; a = 8'h01; b = 8'hFF;
        step();
        drain();
        chk("flag_xor", seen[base], {8'h00, 1'b1, 1'b0});
        chk("flag_pass", seen[base+1], {8'h01, 1'b0, 1'b1});
        chk_lat = 0;

        // Backpressure: 3 items, only STAGES accepted.
        out_ready = 1'b0;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (n < 3) begin
                in_valid = 1'b1; op = 3'(n); a = 8'(8'h31 * (n + 1)); b = 8'h5A;
            end else in_valid = 1'b0;
            step();
            if (acc) n++;
        end
        chk("bp_accepted", n, 2);
        first_y = ref_y(0, 8'h31, 8'h5A);
        chk("bp_hold_y", y, first_y);
        chk("bp_in_ready_low", in_ready, 0);
        out_ready = 1'b1;
        step();
        chk("bp_third_in", acc, 1);
        drain();

        // Reset with 2 results in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin rand_in(); step(); end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_y", y, 0);
        do_reset();
        chk("post_rst_in_ready", in_ready, 1);
        step();
        step();

        // Full throughput.
        chk_lat = 1;
        out_ready = 1'b1;
        n = pops;
        for (int i = 0; i < 20; i++) begin rand_in(); step(); end
        drain();
        chk("thr_count", pops - n, 20);
        chk_lat = 0;

        // Random traffic; hold input until accepted.
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || acc) begin
                if ($urandom_range(0, 3) != 0) rand_in();
                else in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        drain();

`ifdef LOGIC_UNIT_STATS_EN
        do_reset();
        out_ready = 1'b1;
        n = pushes;
        for (int i = 0; i < 70000 && pushes - n < 32'h10001; i++) begin
            rand_in();
            step();
        end
        drain();
        step();
        chk("xfer_wrap", xfer_cnt, 16'h0001);
        chk("busy_idle", busy, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
